// File: rtl/beep_sweep_gen.sv
// beep_sweep_gen: multi-mode square-wave buzzer driver (fixed tone, two-tone,
// triangle/sawtooth sweep, pulsed tone) built from a half-period divider and a step prescaler.
module beep_sweep_gen #(
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned BASE_DIV = 32'h0000_1000,
    parameter int unsigned STEP_SH  = 6,
    parameter int unsigned STEP_W   = 7,
    parameter int unsigned RATE_W   = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [2:0]        mode,
    input  logic [RATE_W-1:0] rate,
    input  logic [DIV_W-1:0]  tone_a,
    input  logic [DIV_W-1:0]  tone_b,
    output logic              beep,
    output logic              busy,
    output logic [STEP_W-1:0] step
);
    localparam int unsigned SUM_W = DIV_W + STEP_W + STEP_SH;

    localparam logic [2:0] M_FIXED    = 3'd0;
    localparam logic [2:0] M_TWO_TONE = 3'd1;
    localparam logic [2:0] M_TRIANGLE = 3'd2;
    localparam logic [2:0] M_SAWTOOTH = 3'd3;
    localparam logic [2:0] M_PULSED   = 3'd4;

    localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_MAX  = {STEP_W{1'b1}};
    localparam logic [RATE_W-1:0] RATE_ZERO = {RATE_W{1'b0}};
    localparam logic [RATE_W-1:0] RATE_ONE  = RATE_W'(1);
    localparam logic [DIV_W-1:0]  DIV_ZERO  = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Half-period for a given mode and step; sweep values clip at the divider's full scale.
    function automatic logic [DIV_W-1:0] hp_f(
        input logic [2:0]        m,
        input logic [STEP_W-1:0] s,
        input logic [DIV_W-1:0]  ta,
        input logic [DIV_W-1:0]  tb
    );
        logic [SUM_W-1:0] sum_v;
        sum_v = SUM_W'(BASE_DIV) + (SUM_W'(s) << STEP_SH);
        case (m)
            M_TWO_TONE:             hp_f = s[0] ? tb : ta;
            M_TRIANGLE, M_SAWTOOTH: hp_f = (|sum_v[SUM_W-1:DIV_W]) ? {DIV_W{1'b1}} : sum_v[DIV_W-1:0];
            default:                hp_f = ta;
        endcase
    endfunction

    state_t            state_r, state_s;
    logic [2:0]        mode_r, mode_s;
    logic [STEP_W-1:0] step_r, step_s;
    logic              dir_down_r, dir_down_s;
    logic [DIV_W-1:0]  cnt_r, cnt_s;
    logic [RATE_W-1:0] pre_r, pre_s;
    logic              beep_r, beep_s;
    logic              busy_r;
    logic              tgl_s;
    logic              gate_s;

    // Next-state, step sequencing, divider and gating for the idle/run machine.
    always_comb begin
        state_s    = state_r;
        mode_s     = mode_r;
        step_s     = step_r;
        dir_down_s = dir_down_r;
        cnt_s      = cnt_r;
        pre_s      = pre_r;
        beep_s     = beep_r;
        tgl_s      = beep_r;
        gate_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                beep_s = 1'b0;
                if (enable) begin
                    state_s    = S_RUN;
                    mode_s     = mode;
                    step_s     = STEP_ZERO;
                    dir_down_s = 1'b0;
                    pre_s      = RATE_ZERO;
                    cnt_s      = hp_f(mode, STEP_ZERO, tone_a, tone_b);
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    state_s = S_IDLE;
                    beep_s  = 1'b0;
                end else begin
                    // >= lets a lowered rate take effect without waiting for a wrap
                    if (pre_r >= rate) begin
                        pre_s = RATE_ZERO;
                        case (mode_r)
                            M_FIXED: step_s = STEP_ZERO;
                            M_TRIANGLE: begin
                                if (!dir_down_r) begin
                                    if (step_r == STEP_MAX) begin
                                        dir_down_s = 1'b1;
                                        step_s     = STEP_MAX - STEP_ONE;
                                    end else begin
                                        step_s = step_r + STEP_ONE;
                                    end
                                end else begin
                                    if (step_r == STEP_ZERO) begin
                                        dir_down_s = 1'b0;
                                        step_s     = STEP_ONE;
                                    end else begin
                                        step_s = step_r - STEP_ONE;
                                    end
                                end
                            end
                            default: step_s = step_r + STEP_ONE;
                        endcase
                    end else begin
                        pre_s = pre_r + RATE_ONE;
                    end
                    // hp is sampled only at reload so a half-period never changes length midway
                    if (cnt_r == DIV_ZERO) begin
                        cnt_s = hp_f(mode_r, step_r, tone_a, tone_b);
                        tgl_s = ~beep_r;
                    end else begin
                        cnt_s = cnt_r - DIV_ONE;
                        tgl_s = beep_r;
                    end
                    gate_s = (mode_r > M_PULSED) || ((mode_r == M_PULSED) && step_s[0]);
                    beep_s = gate_s ? 1'b0 : tgl_s;
                end
            end
            default: begin
                state_s = S_IDLE;
                beep_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; rst returns everything to the idle defaults.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            mode_r     <= 3'd0;
            step_r     <= STEP_ZERO;
            dir_down_r <= 1'b0;
            cnt_r      <= DIV_ZERO;
            pre_r      <= RATE_ZERO;
            beep_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            mode_r     <= mode_s;
            step_r     <= step_s;
            dir_down_r <= dir_down_s;
            cnt_r      <= cnt_s;
            pre_r      <= pre_s;
            beep_r     <= beep_s;
            busy_r     <= (state_s == S_RUN);
        end
    end

    assign beep = beep_r;
    assign busy = busy_r;
    assign step = step_r;

endmodule

// File: doc/beep_sweep_gen.md
Name: beep_sweep_gen

Overview:
- Parametrised multi-mode audible tone/siren generator for the buzzer output; successor to the single fixed-sweep beeper.
- Drives a square wave whose half-period comes from one of several modes: fixed tone, two-tone alternation, triangle sweep, sawtooth sweep, or pulsed (gated) tone.
- Sits between the control FSM (which supplies enable/mode/tone settings) and the buzzer pin.

Parameters:
- DIV_W, 16, width of half-period divider counter and tone inputs.
- BASE_DIV, 16'h1000, sweep base half-period in clk cycles minus 1.
- STEP_SH, 6, left shift applied to sweep step when forming sweep half-period.
- STEP_W, 7, sweep step index width; max step = 2^STEP_W-1.
- RATE_W, 24, width of sweep/alternation prescaler.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, level: 1 = generate tone, 0 = silence.
- mode, input, 3, 0 FIXED, 1 TWO_TONE, 2 TRIANGLE, 3 SAWTOOTH, 4 PULSED, 5-7 reserved (silent).
- rate, input, RATE_W, clk cycles per step advance minus 1.
- tone_a, input, DIV_W, half-period minus 1 for FIXED/PULSED/TWO_TONE phase A.
- tone_b, input, DIV_W, half-period minus 1 for TWO_TONE phase B.
- beep, output, 1, square-wave buzzer drive.
- busy, output, 1, 1 while in RUN.
- step, output, STEP_W, current sweep/phase index.

Behaviour:
- Synchronous reset: state IDLE, beep=0, busy=0, step=0, dir=up, divider count=0, prescaler=0, latched mode=0. rst overrides all inputs.
- States: IDLE, RUN.
- IDLE and enable=1: next edge enters RUN; mode latched into mode_q; step=0, dir=up, prescaler=0, divider loaded with hp(step=0); beep stays 0.
- RUN and enable=0: next edge enters IDLE; beep=0, busy=0. mode changes during RUN are ignored until re-entry.
- busy=1 exactly while in RUN.
- Half-period hp (combinational from mode_q and step):
  - FIXED, PULSED: tone_a.
  - TWO_TONE: step[0] ? tone_b : tone_a.
  - TRIANGLE, SAWTOOTH: BASE_DIV + (step << STEP_SH), computed at DIV_W+STEP_W+STEP_SH bits and saturated to all-ones DIV_W.
  - Reserved: don't care.
- Divider in RUN: if count==0, beep toggles and count reloads with hp; otherwise count decrements. Beep half-period = hp+1 cycles; hp=0 toggles every cycle. New hp takes effect only at reload (no mid-half-period glitch). tone_a/tone_b changes are likewise picked up at reload.
- Prescaler in RUN: if pre >= rate, pre=0 and step advances; otherwise pre increments. The >= compare makes a lowered rate take effect immediately.
- Step advance per mode:
  - FIXED: step held 0.
  - TWO_TONE, PULSED: step+1 (only bit 0 used).
  - SAWTOOTH: step+1, wrapping max→0.
  - TRIANGLE, dir up: at max, dir=down and step=max-1; else step+1.
  - TRIANGLE, dir down: at 0, dir=up and step=1; else step-1.
- PULSED gating:
  - While step[0]=1 (gate closed), beep forced 0; divider keeps counting.
  - When gate reopens, toggling resumes from 0 at the next count==0.
- Reserved modes: RUN entered, busy=1, beep held 0, step advances as in SAWTOOTH.
- rst mid-RUN: beep=0, busy=0 at that edge. If enable is still 1 after rst drops, RUN is re-entered one cycle later.

Test Plan (DIV_W=8, BASE_DIV=4, STEP_SH=1, STEP_W=2, RATE_W=4):
- FIXED, tone_a=3, enable at cycle 0 → busy=1 at cycle 1; beep rises at cycle 5; beep period 8 cycles, 50% duty.
- TRIANGLE, rate=0 → step sequence 0,1,2,3,2,1,0,1…; hp sequence 4,6,8,10,8,…; each new hp observed only at the following reload.
- TWO_TONE, tone_a=1, tone_b=5, rate=15 → 16 cycles of 4-cycle period, then 12-cycle period; alternates every 16 cycles.
- PULSED, tone_a=0, rate=7 → beep toggles every cycle for 8 cycles, then held 0 for 8 cycles; repeats.
- Change mode 0→2 during RUN → behaviour unchanged. Drop enable → beep=0, busy=0 next edge. Re-raise enable → TRIANGLE starts at step 0.
- SAWTOOTH with STEP_SH=7 → hp saturates to 8'hFF for steps 2-3. Assert rst at cycle 20 with enable high → beep=0, busy=0 at that edge; RUN re-entered one cycle after rst release.
